// File: rtl/lcd_ctrl_if.sv
// Bus between lcd_ctrl, its host (characters, clear requests) and the write_cycle engine.
interface lcd_ctrl_if;
    logic       ch_valid;
    logic [7:0] ch_data;
    logic       ch_ready;
    logic       clr_req;
    logic       init_done;
    logic       wr_enable;
    logic       reg_sel;
    logic [7:0] lcd_data;
    logic       wr_finish;

    // master: host plus write_cycle engine; slave: the controller itself
    modport master (output ch_valid, ch_data, clr_req, wr_finish,
                    input  ch_ready, init_done, wr_enable, reg_sel, lcd_data);
    modport slave  (input  ch_valid, ch_data, clr_req, wr_finish,
                    output ch_ready, init_done, wr_enable, reg_sel, lcd_data);
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD controller: power-on wait, init command list, character writes
// with automatic line wrap, and a sticky display-clear request.
module lcd_ctrl #(
    parameter int PON_CYC = 750000,
    parameter int CMD_CYC = 2000,
    parameter int CLR_CYC = 82000
) (
    input  logic      clk,
    input  logic      rst,
    lcd_ctrl_if.slave bus
);
    localparam int MAX_A   = (PON_CYC > CMD_CYC) ? PON_CYC : CMD_CYC;
    localparam int MAX_CYC = (MAX_A > CLR_CYC) ? MAX_A : CLR_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] PON_LAST = CW'(PON_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);

    typedef enum logic [1:0] {PON, WR, DLY, IDLE} state_t;
    typedef enum logic [1:0] {INIT, CHAR, ADDR, CLR} tag_t;

    state_t        state_reg;
    tag_t          tag_reg;
    logic [CW-1:0] cnt_reg;
    logic [1:0]    init_idx_reg;
    logic          row_reg;
    logic [3:0]    col_reg;
    logic          clr_pend_reg;
    logic          init_done_reg;
    logic          wr_enable_reg;
    logic          reg_sel_reg;
    logic [7:0]    lcd_data_reg;
    logic [CW-1:0] dly_last;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // lcd_data still holds the byte just written, so it selects the settle time
    always_comb begin
        dly_last = CMD_LAST;
        if (!reg_sel_reg && (lcd_data_reg == 8'h01 || lcd_data_reg == 8'h02))
            dly_last = CLR_LAST;
    end

    assign bus.ch_ready  = (state_reg == IDLE) && !clr_pend_reg && !bus.clr_req;
    assign bus.init_done = init_done_reg;
    assign bus.wr_enable = wr_enable_reg;
    assign bus.reg_sel   = reg_sel_reg;
    assign bus.lcd_data  = lcd_data_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= PON;
            tag_reg       <= INIT;
            cnt_reg       <= '0;
            init_idx_reg  <= 2'd0;
            row_reg       <= 1'b0;
            col_reg       <= 4'd0;
            clr_pend_reg  <= 1'b0;
            init_done_reg <= 1'b0;
            wr_enable_reg <= 1'b0;
            reg_sel_reg   <= 1'b0;
            lcd_data_reg  <= 8'h00;
        end else begin
            if (bus.clr_req && init_done_reg)
                clr_pend_reg <= 1'b1;
            case (state_reg)
                PON: begin
                    if (cnt_reg == PON_LAST) begin
                        cnt_reg       <= '0;
                        init_idx_reg  <= 2'd0;
                        state_reg     <= WR;
                        tag_reg       <= INIT;
                        wr_enable_reg <= 1'b1;
                        reg_sel_reg   <= 1'b0;
                        lcd_data_reg  <= init_cmd(2'd0);
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                WR: begin
                    if (bus.wr_finish) begin
                        wr_enable_reg <= 1'b0;
                        cnt_reg       <= '0;
                        state_reg     <= DLY;
                    end
                end
                DLY: begin
                    if (cnt_reg != dly_last) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end else begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                        case (tag_reg)
                            INIT: begin
                                if (init_idx_reg == 2'd3) begin
                                    init_done_reg <= 1'b1;
                                end else begin
                                    init_idx_reg  <= init_idx_reg + 2'd1;
                                    state_reg     <= WR;
                                    wr_enable_reg <= 1'b1;
                                    lcd_data_reg  <= init_cmd(init_idx_reg + 2'd1);
                                end
                            end
                            CHAR: begin
                                if (col_reg == 4'd15) begin
                                    // wrap: move the LCD address to the start of the other row
                                    col_reg       <= 4'd0;
                                    row_reg       <= ~row_reg;
                                    state_reg     <= WR;
                                    tag_reg       <= ADDR;
                                    wr_enable_reg <= 1'b1;
                                    reg_sel_reg   <= 1'b0;
                                    lcd_data_reg  <= row_reg ? 8'h80 : 8'hC0;
                                end else begin
                                    col_reg <= col_reg + 4'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                IDLE: begin
                    // a clear arriving this very cycle already blocks ch_ready
                    if (clr_pend_reg || bus.clr_req) begin
                        clr_pend_reg  <= 1'b0;
                        row_reg       <= 1'b0;
                        col_reg       <= 4'd0;
                        state_reg     <= WR;
                        tag_reg       <= CLR;
                        wr_enable_reg <= 1'b1;
                        reg_sel_reg   <= 1'b0;
                        lcd_data_reg  <= 8'h01;
                    end else if (bus.ch_valid) begin
                        state_reg     <= WR;
                        tag_reg       <= CHAR;
                        wr_enable_reg <= 1'b1;
                        reg_sel_reg   <= 1'b1;
                        lcd_data_reg  <= bus.ch_data;
                    end
                end
                default: state_reg <= PON;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: host stimulus pushes expected LCD writes computed from a
// cursor/clear model; a monitor pops and compares each write the controller issues.
module tb_lcd_ctrl;
    localparam int PON = 10;
    localparam int CMD = 4;
    localparam int CLR = 8;
    localparam int WC_LAT = 3;

    typedef struct {
        bit         rs;
        logic [7:0] data;
        int         gap;     // cycles from previous wr_finish (or reset release); -1 = free
        bit         is_clr;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    lcd_ctrl_if bus();

    lcd_ctrl #(.PON_CYC(PON), .CMD_CYC(CMD), .CLR_CYC(CLR)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    int  m_row = 0;
    int  m_col = 0;
    bit  m_init = 1'b0;
    bit  spur_en = 1'b0;
    int  wc_cnt = 0;
    int  cyc = 0;
    bit  mon_prev_en = 1'b0;
    bit  mon_fin = 1'b0;
    bit  mon_have = 1'b0;
    bit  mon_hold_bad = 1'b0;
    int  mon_ref = 0;
    wr_t mon_cur;
    int  gap;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit clr_queued();
        foreach (exp_q[i]) if (exp_q[i].is_clr) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_init();
        exp_q.push_back('{1'b0, 8'h38, PON, 1'b0});
        exp_q.push_back('{1'b0, 8'h0C, CMD, 1'b0});
        exp_q.push_back('{1'b0, 8'h01, CMD, 1'b0});
        exp_q.push_back('{1'b0, 8'h06, CLR, 1'b0});
    endtask

    task automatic push_char(input logic [7:0] d);
        exp_q.push_back('{1'b1, d, -1, 1'b0});
        m_col++;
        if (m_col == 16) begin
            m_col = 0;
            m_row = 1 - m_row;
            exp_q.push_back('{1'b0, (m_row == 1) ? 8'hC0 : 8'h80, CMD, 1'b0});
        end
    endtask

    task automatic push_clear();
        if (!m_init || clr_queued()) return;
        exp_q.push_back('{1'b0, 8'h01, -1, 1'b1});
        m_row = 0;
        m_col = 0;
    endtask

    // ---------------- write_cycle model ----------------
    initial begin
        bus.wr_finish = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst || bus.wr_finish) begin
                bus.wr_finish = 1'b0;
                wc_cnt = 0;
            end else if (bus.wr_enable) begin
                wc_cnt++;
                if (wc_cnt == WC_LAT) bus.wr_finish = 1'b1;
            end else if (spur_en && $urandom_range(0, 9) == 0) begin
                bus.wr_finish = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            mon_fin = bus.wr_finish;
            #1;
            if (!rst) begin
                mon_ref = cyc;
                mon_prev_en = 1'b0;
                mon_have = 1'b0;
                continue;
            end
            if (mon_fin && mon_prev_en && mon_have) begin
                mon_ref = cyc;
                check("hold_during_wr", int'(mon_hold_bad), 0);
                mon_have = 1'b0;
            end
            if (bus.wr_enable && !mon_prev_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual rs=%0d data=0x%0h required none (cycle %0d)",
                             bus.reg_sel, bus.lcd_data, cyc);
                end else begin
                    mon_cur = exp_q.pop_front();
                    mon_have = 1'b1;
                    mon_hold_bad = 1'b0;
                    check("wr_reg_sel", int'(bus.reg_sel), int'(mon_cur.rs));
                    check("wr_lcd_data", int'(bus.lcd_data), int'(mon_cur.data));
                    if (mon_cur.gap >= 0) check("wr_gap", cyc - mon_ref, mon_cur.gap);
                end
            end
            if (bus.wr_enable && mon_have &&
                (bus.reg_sel !== mon_cur.rs || bus.lcd_data !== mon_cur.data))
                mon_hold_bad = 1'b1;
            mon_prev_en = bus.wr_enable;
        end
    end

    // ---------------- host helpers ----------------
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic send_char(input logic [7:0] d);
        bit got = 1'b0;
        bus.ch_valid = 1'b1;
        bus.ch_data = d;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            got = bus.ch_ready;
            @(posedge clk);
        end
        if (!got) begin
            check("ch_ready_timeout", 0, 1);
            bus.ch_valid = 1'b0;
            return;
        end
        push_char(d);
        #3;
        bus.ch_valid = 1'b0;
        check("char_wr_enable", int'(bus.wr_enable), 1);
        check("char_reg_sel", int'(bus.reg_sel), 1);
        check("char_lcd_data", int'(bus.lcd_data), int'(d));
    endtask

    // cycles from the nfin-th wr_finish until ch_ready is seen high
    task automatic wait_idle(input int nfin, output int g);
        int seen = 0;
        int lim = 0;
        g = -1;
        while (seen < nfin && lim < 3000) begin
            @(posedge clk);
            if (bus.wr_finish) seen++;
            lim++;
        end
        if (seen < nfin) begin
            check("wr_finish_timeout", seen, nfin);
            return;
        end
        g = 0;
        while (lim < 3000) begin
            @(negedge clk);
            if (bus.ch_ready) return;
            @(posedge clk);
            g++;
            lim++;
        end
        check("idle_timeout", 0, 1);
        g = -1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.ch_valid = 1'b0;
        bus.ch_data = 8'h00;
        bus.clr_req = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("rst_wr_enable", int'(bus.wr_enable), 0);
        check("rst_reg_sel", int'(bus.reg_sel), 0);
        check("rst_lcd_data", int'(bus.lcd_data), 0);
        check("rst_ch_ready", int'(bus.ch_ready), 0);
        check("rst_init_done", int'(bus.init_done), 0);

        @(posedge clk);
        #2;
        rst = 1'b1;
        push_init();
        tick();
        tick();
        bus.clr_req = 1'b1;      // before init_done: must be ignored
        push_clear();
        tick();
        bus.clr_req = 1'b0;
        check("pon_init_done", int'(bus.init_done), 0);
        check("pon_ch_ready", int'(bus.ch_ready), 0);
        wait_idle(4, gap);
        check("init_tail_gap", gap, CMD);
        check("init_done", int'(bus.init_done), 1);
        m_init = 1'b1;

        tick();
        send_char(8'h41);
        wait_idle(1, gap);
        check("char_idle_gap", gap, CMD);

        // clear and character offered together: clear wins
        tick();
        bus.clr_req = 1'b1;
        push_clear();
        bus.ch_valid = 1'b1;
        bus.ch_data = 8'h5A;
        @(negedge clk);
        check("ready_with_clr", int'(bus.ch_ready), 0);
        @(posedge clk);
        #3;
        bus.clr_req = 1'b0;
        wait_idle(1, gap);
        check("clr_dly_gap", gap, CLR);
        @(posedge clk);
        push_char(8'h5A);
        #3;
        bus.ch_valid = 1'b0;
        check("post_clr_char", int'(bus.lcd_data), 8'h5A);

        // clear during a character write: char, its delay, then the clear
        tick();
        send_char(8'h42);
        bus.clr_req = 1'b1;
        push_clear();
        tick();
        bus.clr_req = 1'b0;
        wait_idle(1, gap);
        check("char_then_clr_gap", gap, CMD + 1 + WC_LAT + CLR);

        // two full rows from 0/0: expect 0xC0 then 0x80
        tick();
        for (int i = 0; i < 32; i++) begin
            send_char(8'(32 + $urandom_range(0, 94)));
            repeat ($urandom_range(0, 3)) tick();
        end

        // randomized mix with spurious wr_finish outside WR
        spur_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 99) < 80) begin
                send_char(8'($urandom));
            end else begin
                bus.clr_req = 1'b1;
                push_clear();
                tick();
                bus.clr_req = 1'b0;
            end
            repeat ($urandom_range(0, 12)) tick();
        end
        spur_en = 1'b0;

        // reset in the middle of a write
        repeat (60) tick();
        send_char(8'h77);
        tick();
        rst = 1'b0;
        #1;
        check("arst_wr_enable", int'(bus.wr_enable), 0);
        check("arst_init_done", int'(bus.init_done), 0);
        check("arst_lcd_data", int'(bus.lcd_data), 0);
        check("arst_ch_ready", int'(bus.ch_ready), 0);
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        m_init = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        push_init();
        wait_idle(4, gap);
        check("reinit_tail_gap", gap, CMD);
        check("reinit_done", int'(bus.init_done), 1);
        m_init = 1'b1;
        tick();
        send_char(8'h31);
        send_char(8'h32);

        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.ch_ready) break;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 The block SHALL have parameter PON_CYC, default 750000, power-on wait in clk cycles (15 ms at 50 MHz).
REQ-002 The block SHALL have parameter CMD_CYC, default 2000, post-command wait in clk cycles (40 us).
REQ-003 The block SHALL have parameter CLR_CYC, default 82000, post-clear/home wait in clk cycles (1.64 ms).
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 ch_valid  input  1  host offers a character.
REQ-007 ch_data  input  8  character code.
REQ-008 ch_ready  output  1  controller accepts character this cycle.
REQ-009 clr_req  input  1  single-cycle pulse requesting display clear and cursor home.
REQ-010 init_done  output  1  init sequence complete; stays high until reset.
REQ-011 wr_enable  output  1  start/hold request to write_cycle.
REQ-012 reg_sel  output  1  RS to write_cycle: 0 command, 1 data.
REQ-013 lcd_data  output  8  byte presented to the LCD bus.
REQ-014 wr_finish  input  1  write_cycle completion strobe.

Function
REQ-015 The FSM SHALL have states PON, WR, DLY, IDLE; WR/DLY SHALL carry a return tag: INIT, CHAR, ADDR, CLR.
REQ-016 PON: count PON_CYC cycles, then enter WR(INIT) with command 0x38.
REQ-017 The init command list SHALL be 0x38, 0x0C, 0x01, 0x06, in that order, all with reg_sel=0.
REQ-018 WR: wr_enable=1; reg_sel and lcd_data SHALL be held constant until wr_finish=1 is sampled.
REQ-019 On wr_finish=1 in WR, the next cycle SHALL have wr_enable=0 and enter DLY.
REQ-020 wr_finish outside WR SHALL be ignored.
REQ-021 DLY length SHALL be CLR_CYC cycles when the command byte was 0x01 or 0x02, otherwise CMD_CYC cycles, counted from the first DLY cycle.
REQ-022 DLY(INIT) SHALL issue the next init command; after the 4th command it SHALL set init_done=1 and enter IDLE.
REQ-023 ch_ready SHALL be 1 only in IDLE with no clear request pending.
REQ-024 On ch_valid & ch_ready at edge N, ch_data SHALL be latched and WR(CHAR) entered with wr_enable=1, reg_sel=1 in cycle N+1.
REQ-025 A cursor (row 0..1, col 0..15) SHALL reset to 0/0 and advance after each CHAR write.
REQ-026 When the CHAR write was at col 15: col←0; row toggles; WR(ADDR) SHALL issue 0xC0 (new row 1) or 0x80 (new row 0) before IDLE.
REQ-027 Otherwise DLY(CHAR) SHALL return to IDLE.
REQ-028 clr_req SHALL set a sticky pending flag in any state after init_done.
REQ-029 clr_req before init_done SHALL be ignored.
REQ-030 In IDLE, a pending clear SHALL beat ch_valid: issue 0x01 via WR(CLR), clear the flag on entering WR, and reset the cursor to 0/0.
REQ-031 A clr_req arriving during WR(CLR) or DLY(CLR) SHALL set the flag again, causing one further clear.
REQ-032 Delay counters SHALL be sized for the largest parameter; no wrap shall occur within a wait.

Reset
REQ-033 While rst=0, all outputs SHALL be 0, the state SHALL be PON with counter 0, cursor 0/0, and the clear flag 0.
REQ-034 Reset assertion mid-operation SHALL immediately drop wr_enable and restart the full power-on sequence on release.

Verification (PON_CYC=10, CMD_CYC=4, CLR_CYC=8; write_cycle model pulses wr_finish 3 cycles after wr_enable rises)
REQ-035 Release rst -> wr_enable rises 10 cycles later with lcd_data=0x38; the sequence 0x38, 0x0C, 0x01, 0x06 follows, all with reg_sel=0, 4/4/8/4-cycle gaps after each wr_finish; init_done=1 afterwards.
REQ-036 After init, ch_valid with 0x41 -> ch_ready=1 in the accept cycle; next cycle wr_enable=1, reg_sel=1, lcd_data=0x41; return to IDLE 4 cycles after wr_finish.
REQ-037 Write 16 chars -> after the 16th, a command 0xC0 with reg_sel=0; 16 more chars -> command 0x80.
REQ-038 clr_req and ch_valid together in IDLE -> 0x01 issued first (8-cycle wait), cursor 0/0, then the character is accepted.
REQ-039 clr_req pulse during a CHAR write -> character completes, then 0x01 is issued; ch_ready=0 until the clear's DLY ends.
REQ-040 rst asserted while wr_enable=1 -> wr_enable=0 and init_done=0 asynchronously; after release, 0x38 is reissued after 10 cycles.
